// File: rtl/user_pkg.sv
// Shared types for the user-domain OBI stream writer: FSM states, OBI request/response
// structs and the packed-word record that travels from the byte packer to the word buffer.
package user_pkg;

    localparam int UserWrLenWidth = 16;

    typedef enum logic [1:0] {WrIdle, WrRun, WrDrain, WrDone} user_wr_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } user_wr_word_t;

    // Byte enables covering lanes 0..last_lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/user_obi_wr_pack.sv
// Byte-to-word packer: byte n of a transfer lands in lane n%4; a word is emitted on the
// same cycle as the byte that completes it (lane 3 or the final byte of the transfer).
// Handshake: a byte moves when in_valid && in_ready; a word moves when out_valid && out_ready.
// in_ready mirrors out_ready, so a byte is only taken when its word (if any) can be stored.
// Optional USER_OBI_STREAM_WRITER_BYTE_STRB_EN: trailing partial word carries only its valid lanes.
module user_obi_wr_pack
    import user_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output user_wr_word_t out_word,
    input  logic          out_ready
);

    logic [1:0]  lane;
    logic [23:0] acc;
    logic        accept;
    logic        flush;

    assign in_ready  = out_ready;
    assign accept    = in_valid && in_ready;
    assign flush     = (lane == 2'd3) || in_last;
    assign out_valid = in_valid && flush;

    // Lanes above the current byte stay zero, which pads a trailing partial word.
    always_comb begin
        out_word = '0;
        case (lane)
            2'd0:    out_word.wdata = {24'h00_0000, in_data};
            2'd1:    out_word.wdata = {16'h0000, in_data, acc[7:0]};
            2'd2:    out_word.wdata = {8'h00, in_data, acc[15:0]};
            default: out_word.wdata = {in_data, acc};
        endcase
`ifdef USER_OBI_STREAM_WRITER_BYTE_STRB_EN
        out_word.be = lane_mask(lane);
`else
        out_word.be = 4'b1111;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            acc  <= '0;
        end else if (clear) begin
            lane <= 2'd0;
            acc  <= '0;
        end else if (accept) begin
            if (flush) begin
                lane <= 2'd0;
                acc  <= '0;
            end else begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    acc[7:0]   <= in_data;
                    2'd1:    acc[15:8]  <= in_data;
                    default: acc[23:16] <= in_data;
                endcase
            end
        end
    end

endmodule

// File: rtl/user_obi_stream_writer.sv
// OBI manager that packs an accelerator byte stream into little-endian words and writes them
// to memory from a programmed base address. Optional macro: USER_OBI_STREAM_WRITER_BYTE_STRB_EN.
module user_obi_stream_writer
    import user_pkg::*;
#(
    parameter type         obi_req_t      = mgr_obi_req_t,
    parameter type         obi_rsp_t      = mgr_obi_rsp_t,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned WordFifoDepth  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [31:0]               base_addr_i,
    input  logic [UserWrLenWidth-1:0] len_i,
    input  logic [7:0]                data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output obi_req_t                  obi_req_o,
    input  obi_rsp_t                  obi_rsp_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam int unsigned PtrW   = (WordFifoDepth > 1) ? $clog2(WordFifoDepth) : 1;
    localparam int unsigned CntW   = $clog2(WordFifoDepth + 1);
    localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

    user_wr_state_e            state, next_state;
    logic [31:0]               addr;
    logic [UserWrLenWidth-1:0] bytes_left;
    logic [2:0]                out_cnt;
    logic                      error;

    user_wr_word_t             mem [WordFifoDepth];
    logic [PtrW-1:0]           wr_ptr, rd_ptr;
    logic [CntW-1:0]           count;
    logic                      fifo_full, fifo_empty, push, pop;
    user_wr_word_t             head, pack_word;

    logic                      start_accept, in_run, pack_valid, pack_in_ready;
    logic                      byte_accept, issue, grant, rsp_valid;
    logic                      unused_rdata;

    assign unused_rdata = ^obi_rsp_i.r.rdata;

    assign start_accept = (state == WrIdle) && start_i;
    assign in_run       = (state == WrRun) && (bytes_left != '0);
    assign ready_o      = in_run && pack_in_ready;
    assign byte_accept  = valid_i && ready_o;

    assign fifo_full  = (count == CntW'(WordFifoDepth));
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];

    // Stale responses after a mid-transfer reset are ignored rather than underflowing the count.
    assign rsp_valid = obi_rsp_i.rvalid && (out_cnt != 3'd0);
    assign issue     = ((state == WrRun) || (state == WrDrain)) && !fifo_empty &&
                       ((out_cnt < MaxOut) || rsp_valid);
    assign grant     = issue && obi_rsp_i.gnt;
    assign push      = pack_valid && !fifo_full;
    assign pop       = grant;

    user_obi_wr_pack i_pack (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (start_accept),
        .in_valid  (valid_i && in_run),
        .in_data   (data_i),
        .in_last   (bytes_left == UserWrLenWidth'(1)),
        .in_ready  (pack_in_ready),
        .out_valid (pack_valid),
        .out_word  (pack_word),
        .out_ready (!fifo_full)
    );

    always_comb begin
        next_state = state;
        case (state)
            WrIdle: begin
                if (start_i) begin
                    if ((base_addr_i[1:0] != 2'b00) || (len_i == '0)) next_state = WrDone;
                    else                                               next_state = WrRun;
                end
            end
            WrRun:   if (byte_accept && (bytes_left == UserWrLenWidth'(1))) next_state = WrDrain;
            WrDrain: if (fifo_empty && (out_cnt == 3'd0)) next_state = WrDone;
            WrDone:  next_state = WrIdle;
            default: next_state = WrIdle;
        endcase
    end

    // Request fields are only driven while req is up; they cannot change until the grant.
    always_comb begin
        obi_req_o     = '0;
        obi_req_o.req = issue;
        if (issue) begin
            obi_req_o.a.addr  = addr;
            obi_req_o.a.we    = 1'b1;
            obi_req_o.a.be    = head.be;
            obi_req_o.a.wdata = head.wdata;
        end
    end

    assign busy_o  = (state != WrIdle);
    assign done_o  = (state == WrDone);
    assign error_o = error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= WrIdle;
            addr       <= '0;
            bytes_left <= '0;
            out_cnt    <= 3'd0;
            error      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= next_state;
            if (start_accept) begin
                addr       <= base_addr_i;
                bytes_left <= len_i;
                error      <= (base_addr_i[1:0] != 2'b00);
            end else begin
                if (grant)                          addr       <= addr + 32'd4;
                if (byte_accept)                    bytes_left <= bytes_left - UserWrLenWidth'(1);
                if (rsp_valid && obi_rsp_i.r.err)   error      <= 1'b1;
            end
            case ({grant, rsp_valid})
                2'b10:   out_cnt <= out_cnt + 3'd1;
                2'b01:   out_cnt <= out_cnt - 3'd1;
                default: out_cnt <= out_cnt;
            endcase
            if (push) wr_ptr <= (wr_ptr == PtrW'(WordFifoDepth - 1)) ? '0 : wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PtrW'(WordFifoDepth - 1)) ? '0 : rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= pack_word;
    end

endmodule
